// File: rtl/shift_register_pkg.sv
// Shared constants and helpers for the framed shift register.
// Bit-order selectors and the frame-counter width rule live here.
package shift_register_pkg;

  localparam bit SHIFT_MSB_FIRST = 1'b1;
  localparam bit SHIFT_LSB_FIRST = 1'b0;

  // A one-bit counter is still needed for the smallest legal register.
  function automatic int cnt_width(input int width);
    cnt_width = (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/frame_bit_counter.sv
// Counts bits accepted in the current frame and flags the frame-completing shift.
// Clear has priority over increment; reset is synchronous active-low.
module frame_bit_counter
  import shift_register_pkg::*;
#(
  parameter int WIDTH = 8,
  localparam int CW = cnt_width(WIDTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          inc,
  output logic [CW-1:0] cnt,
  output logic          wrap
);

  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
  localparam logic [CW-1:0] ONE_CNT  = CW'(1);

  logic [CW-1:0] cnt_r;
  logic [CW-1:0] cnt_nxt_s;
  logic          wrap_s;

  // Next count: explicit wrap so non-power-of-two widths also stay in range.
  always_comb begin
    cnt_nxt_s = cnt_r;
    wrap_s    = 1'b0;
    if (clr) begin
      cnt_nxt_s = {CW{1'b0}};
    end else if (inc) begin
      if (cnt_r == LAST_CNT) begin
        cnt_nxt_s = {CW{1'b0}};
        wrap_s    = 1'b1;
      end else begin
        cnt_nxt_s = cnt_r + ONE_CNT;
      end
    end else begin
      cnt_nxt_s = cnt_r;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_r <= {CW{1'b0}};
    end else begin
      cnt_r <= cnt_nxt_s;
    end
  end

  assign cnt  = cnt_r;
  assign wrap = wrap_s;

endmodule

// File: rtl/shift_register_framed.sv
// Serial-in shift register with parallel load and WIDTH-bit frame capture.
// PQ latches the post-shift word on each completed frame; PV pulses the cycle after.
module shift_register_framed
  import shift_register_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter bit               MSB_FIRST = SHIFT_MSB_FIRST,
  parameter logic [WIDTH-1:0] INIT      = {WIDTH{1'b0}}
) (
  input  logic                        C,
  input  logic                        R_N,
  input  logic                        CE,
  input  logic                        SI,
  input  logic                        LOAD,
  input  logic [WIDTH-1:0]            PI,
  output logic                        SO,
  output logic [WIDTH-1:0]            PO,
  output logic [WIDTH-1:0]            PQ,
  output logic                        PV,
  output logic [cnt_width(WIDTH)-1:0] CNT
);

  logic [WIDTH-1:0] po_r;
  logic [WIDTH-1:0] pq_r;
  logic             pv_r;
  logic [WIDTH-1:0] shift_s;
  logic             shift_en_s;
  logic             wrap_s;

  assign shift_en_s = CE & ~LOAD;

  frame_bit_counter #(
    .WIDTH (WIDTH)
  ) u_cnt (
    .clk   (C),
    .rst_n (R_N),
    .clr   (LOAD),
    .inc   (shift_en_s),
    .cnt   (CNT),
    .wrap  (wrap_s)
  );

  // Shifted image of the register for the configured bit order.
  always_comb begin
    shift_s = po_r;
    if (MSB_FIRST) begin
      shift_s = {po_r[WIDTH-2:0], SI};
    end else begin
      shift_s = {SI, po_r[WIDTH-1:1]};
    end
  end

  // Data path: reset, then load, then shift, then hold; PV is a one-cycle echo of wrap.
  always_ff @(posedge C) begin
    if (!R_N) begin
      po_r <= INIT;
      pq_r <= {WIDTH{1'b0}};
      pv_r <= 1'b0;
    end else if (LOAD) begin
      po_r <= PI;
      pv_r <= 1'b0;
    end else if (CE) begin
      po_r <= shift_s;
      pv_r <= wrap_s;
      if (wrap_s) begin
        pq_r <= shift_s;
      end else begin
        pq_r <= pq_r;
      end
    end else begin
      pv_r <= 1'b0;
    end
  end

  assign SO = MSB_FIRST ? po_r[WIDTH-1] : po_r[0];
  assign PO = po_r;
  assign PQ = pq_r;
  assign PV = pv_r;

endmodule

// File: doc/shift_register_framed.md
SHIFT_REGISTER_FRAMED -- requirements
Module: shift_register_framed

Interface
REQ-001 Parameter WIDTH, default 8, register length in bits; SHALL be >= 2.
REQ-002 Parameter MSB_FIRST, default 1; 1 = SI enters bit 0 and the oldest bit leaves at bit WIDTH-1; 0 = mirrored.
REQ-003 Parameter INIT, default all-zero, WIDTH bits; shift register value after reset.
REQ-004 C  input  1  clock; all state SHALL update on the rising edge only.
REQ-005 R_N  input  1  reset; one clock, reset is synchronous and active-low.
REQ-006 CE  input  1  shift enable; one bit is accepted per rising edge while high.
REQ-007 SI  input  1  serial data in.
REQ-008 LOAD  input  1  parallel load strobe.
REQ-009 PI  input  WIDTH  parallel load data.
REQ-010 SO  output  1  serial data out; the bit that leaves on the next shift.
REQ-011 PO  output  WIDTH  live shift register contents.
REQ-012 PQ  output  WIDTH  captured frame; holds the last complete WIDTH-bit word.
REQ-013 PV  output  1  frame-valid pulse, one cycle per captured frame.
REQ-014 CNT  output  clog2(WIDTH)  bits accepted in the current frame, 0..WIDTH-1.

Function
REQ-015 Priority per edge SHALL be: reset, then LOAD, then CE shift, then hold.
REQ-016 Shift, MSB_FIRST=1: PO <= {PO[WIDTH-2:0], SI}; MSB_FIRST=0: PO <= {SI, PO[WIDTH-1:1]}.
REQ-017 SO SHALL be PO[WIDTH-1] when MSB_FIRST=1, else PO[0]; combinational from the register, no added latency.
REQ-018 Each shift SHALL increment CNT; a shift at CNT=WIDTH-1 SHALL wrap CNT to 0 and complete the frame.
REQ-019 On frame completion, PQ SHALL take the post-shift PO value on the same edge, and PV SHALL be 1 for exactly the following cycle.
REQ-020 PV SHALL be 0 on every cycle that does not follow a frame-completing edge; with CE held high, PV SHALL pulse every WIDTH cycles with no gap or loss.
REQ-021 LOAD=1: PO <= PI, CNT <= 0, PV <= 0, PQ unchanged; SI and CE are ignored on that edge.
REQ-022 LOAD on the same edge as a would-be WIDTH-th bit SHALL discard that frame: no PV, PQ unchanged.
REQ-023 CE=0 and LOAD=0: PO, CNT and PQ hold; PV <= 0; CE gaps inside a frame SHALL not affect the captured word.
REQ-024 PQ SHALL change only on frame completion or reset.

Reset
REQ-025 R_N=0 at an edge: PO <= INIT, PQ <= 0, CNT <= 0, PV <= 0; overrides LOAD and CE.
REQ-026 Reset mid-frame SHALL discard the partial frame; the next PV SHALL require WIDTH further shifts after reset release.
REQ-027 Before the first reset edge, outputs are undefined; no asynchronous path from R_N exists.

Structure
REQ-028 Package shift_register_pkg SHALL hold the MSB_FIRST/LSB_FIRST constants and the CNT-width function (clog2 of WIDTH, minimum 1).
REQ-029 Sub-module frame_bit_counter SHALL implement CNT, wrap detection and synchronous clear; the data path stays in the top module.

Verification (WIDTH=8 unless stated; bits listed in shift order)
REQ-030 MSB_FIRST=1, CE=1, SI=1,1,0,1,1,1,0,0 -> PQ=8'hDC and PV=1 for one cycle after the 8th edge; CNT 0..7 then 0.
REQ-031 MSB_FIRST=0, same bits -> PQ=8'h3B, single-cycle PV.
REQ-032 LOAD with PI=8'hA5, then 8 shifts with SI=0 -> SO=1,0,1,0,0,1,0,1; PV follows the 8th shift with PQ=8'h00.
REQ-033 5 bits shifted, then R_N=0 for one edge -> PO=INIT, CNT=0, PV=0; PV only after 8 more shifts.
REQ-034 CE toggled 1/0 between the 8 bits of REQ-030 -> same PQ=8'hDC, one PV, PQ stable during gaps.
REQ-035 LOAD asserted on the edge of the 8th bit -> no PV, PQ keeps its prior value, CNT=0, PO=PI.
